ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
- Parametrised instruction fetch queue between the fetch stage (PC generation, align buffer, compressed decoder) and decode.
- Decouples fetch from decode stalls: the fetch side keeps pushing decoded instructions while decode is stalled.
- Each entry holds PC, expanded instruction, compressed flag, exception type and prediction info.
- Supports flush on redirect, and poison-blocking after a faulting fetch.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 32, address/instruction width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  discard all entries (mispredict/trap redirect)
- in_valid_i  in  1  fetch side has an instruction
- in_ready_o  out  1  queue accepts a push this cycle
- in_pc_i  in  XLEN  instruction PC
- in_inst_i  in  XLEN  expanded 32-bit instruction
- in_is_comp_i  in  1  original instruction was 16-bit
- in_exc_i  in  exc_type_e  fetch exception (NO_EXCEPTION when clean)
- in_spec_i  in  predict_info_t  branch prediction (taken, target pc)
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  decode consumes head this cycle
- out_pc_o / out_inst_o / out_is_comp_o / out_exc_o / out_spec_o  out  as inputs  head entry fields
- count_o  out  CNT_W  current occupancy
- poisoned_o  out  1  exception entry queued, further pushes blocked

Behaviour:
- Storage: DEPTH-entry register array. Write pointer wr_ptr and read pointer rd_ptr are each log2(DEPTH) bits, wrap modulo DEPTH. Occupancy cnt runs 0..DEPTH.
- Reset (rst_ni=0 at posedge): wr_ptr=0, rd_ptr=0, cnt=0, poison=0. Resulting outputs: out_valid_o=0, in_ready_o=1, count_o=0, poisoned_o=0. Data array is not reset. Reset takes priority over every other input, including mid-burst.
- push = in_valid_i & in_ready_o. pop = out_valid_o & out_ready_i.
- in_ready_o = (cnt != DEPTH) & !poison. It is registered-state only, with no combinational path from out_ready_i.
- out_valid_o = (cnt != 0). Head fields are read combinationally from array[rd_ptr]. Push-to-pop latency is 1 cycle (bypass is optional, see below).
- Push writes array[wr_ptr], then wr_ptr+1. Pop advances rd_ptr+1.
- Occupancy update: push & pop together leaves cnt unchanged; push only gives cnt+1; pop only gives cnt-1.
- Full (cnt=DEPTH): in_ready_o=0. A pop in that cycle does not enable a push in the same cycle.
- Empty (cnt=0): out_valid_o=0, and out_ready_i is ignored.
- Poison: a push with in_exc_i != NO_EXCEPTION sets poison=1 on the next edge. While poison=1, in_ready_o=0. Queued entries continue to drain normally. Poison is cleared only by flush_i or reset.
- Flush: flush_i=1 at posedge gives wr_ptr=rd_ptr=0, cnt=0, poison=0. Flush has priority over push and pop in the same cycle; both are dropped. After a flush, out_valid_o=0 and in_ready_o=1.
- Outputs out_* are undefined when out_valid_o=0. The consumer must not sample them then.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined: when cnt=0, in_valid_i=1 and in_ready_o=1, the input fields drive out_* combinationally and out_valid_o=1 in the same cycle.
  - If out_ready_i=1 that cycle, the entry is consumed directly and is not written; pointers and cnt are unchanged.
  - If out_ready_i=0, the entry is written as a normal push.
  - Poison-setting still applies to a bypassed exception entry.
- Undefined: no bypass; minimum push-to-pop latency is 1 cycle.

Decomposition:
- exc_type_e, predict_info_t and XLEN are existing tcore_param items.
- Add fetchq_entry_t (pc, inst, is_comp, exc, spec) to tcore_param so decode can reuse it.
- Pointer/counter logic lives in the top module.
- One natural sub-module: fetchq_ptr_ctrl (pointers, cnt, full/empty, poison). The data array stays in ifetch_queue.

Test Plan:
- Fill/drain, DEPTH=4, out_ready_i=0: push PCs 0x4000_0000, 0x4000_0004, 0x4000_0006, 0x4000_000A.
  - count_o goes 1,2,3,4; in_ready_o=0 at 4.
  - Then out_ready_i=1: entries pop in order over 4 cycles, ending with count_o=0 and out_valid_o=0.
- Simultaneous push/pop at cnt=2 for 10 cycles: count_o stays 2; pointers wrap past index 3 with no loss or duplication (scoreboard match).
- Flush with push and pop asserted at cnt=3: next cycle count_o=0, out_valid_o=0, in_ready_o=1; the pushed entry never appears.
- Poison: push ILLEGAL_INSTRUCTION entry at cnt=1.
  - Next cycle poisoned_o=1, in_ready_o=0; in_valid_i held high for 5 cycles is refused.
  - Both entries drain; flush_i clears poison.
- Reset mid-operation at cnt=3 with poison=1: next cycle count_o=0, poisoned_o=0, in_ready_o=1, out_valid_o=0.
- With FETCHQ_BYPASS_EN, empty queue, push 0x4000_0010 with out_ready_i=1: out_valid_o=1 and out_pc_o=0x4000_0010 in the same cycle; count_o stays 0.

Source files
------------

// File: rtl/tcore_param.sv
// Shared core types: fetch exception codes, branch prediction info and the
// fetch queue entry record reused by decode.
package tcore_param;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    NO_EXCEPTION          = 3'd0,
    INSTR_ADDR_MISALIGNED = 3'd1,
    INSTR_ACCESS_FAULT    = 3'd2,
    ILLEGAL_INSTRUCTION   = 3'd3,
    INSTR_PAGE_FAULT      = 3'd4
  } exc_type_e;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } predict_info_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            is_comp;
    exc_type_e       exc;
    predict_info_t   spec;
  } fetchq_entry_t;

  function automatic logic is_fault(exc_type_e exc);
    return exc != NO_EXCEPTION;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-to-decode handshake bundle: push side (in_*) and head side (out_*).
// master = fetch/decode pair driving the queue, slave = the queue itself.
interface ifetch_queue_if import tcore_param::*; ();

  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] in_pc_i;
  logic [XLEN-1:0] in_inst_i;
  logic            in_is_comp_i;
  exc_type_e       in_exc_i;
  predict_info_t   in_spec_i;

  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [XLEN-1:0] out_inst_o;
  logic            out_is_comp_o;
  exc_type_e       out_exc_o;
  predict_info_t   out_spec_o;

  modport master (
    output in_valid_i, in_pc_i, in_inst_i, in_is_comp_i, in_exc_i, in_spec_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o, out_pc_o, out_inst_o, out_is_comp_o, out_exc_o, out_spec_o
  );

  modport slave (
    input  in_valid_i, in_pc_i, in_inst_i, in_is_comp_i, in_exc_i, in_spec_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o, out_pc_o, out_inst_o, out_is_comp_o, out_exc_o, out_spec_o
  );

endinterface

// File: rtl/fetchq_ptr_ctrl.sv
// Pointer, occupancy and poison bookkeeping for the instruction fetch queue.
module fetchq_ptr_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             poison_set_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             poison_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             poison_q, poison_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the branches can leave a value unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    poison_d = poison_q;

    if (flush_i) begin
      // A redirect drops both the push and the pop of this cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      poison_d = 1'b0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase

      if (poison_set_i) poison_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      poison_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      poison_q <= poison_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign cnt_o    = cnt_q;
  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign poison_o = poison_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue between fetch and decode, with flush and
// poison-after-fault. Define FETCHQ_BYPASS_EN for empty-queue same-cycle bypass.
module ifetch_queue import tcore_param::*; #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  ifetch_queue_if.slave    fq,
  output logic [CNT_W-1:0] count_o,
  output logic             poisoned_o
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ifetch_queue: DEPTH must be a power of two >= 2");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full, empty, poison;

  logic             in_ready, out_valid;
  logic             push, pop;
  logic             wr_en, rd_en, poison_set;
  fetchq_entry_t    in_entry, head_entry;
  fetchq_entry_t    mem_q [DEPTH];
  fetchq_entry_t    mem_d [DEPTH];

  always_comb begin
    in_entry.pc      = fq.in_pc_i;
    in_entry.inst    = fq.in_inst_i;
    in_entry.is_comp = fq.in_is_comp_i;
    in_entry.exc     = fq.in_exc_i;
    in_entry.spec    = fq.in_spec_i;
  end

  // Ready depends only on registered state, never on out_ready_i, so a pop
  // while full cannot open room for a push in the same cycle.
  assign in_ready   = !full && !poison;
  assign push       = fq.in_valid_i && in_ready;
  assign pop        = out_valid && fq.out_ready_i;
  assign poison_set = push && is_fault(fq.in_exc_i);

`ifdef FETCHQ_BYPASS_EN
  logic bypass;

  assign bypass    = empty && fq.in_valid_i && in_ready;
  assign out_valid = !empty || bypass;
  assign head_entry = bypass ? in_entry : mem_q[rd_ptr];
  // A bypassed entry taken by decode this cycle never touches the array.
  assign wr_en     = push && !(bypass && fq.out_ready_i);
  assign rd_en     = pop && !empty;
`else
  assign out_valid  = !empty;
  assign head_entry = mem_q[rd_ptr];
  assign wr_en      = push;
  assign rd_en      = pop;
`endif

  fetchq_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_i       (wr_en),
    .pop_i        (rd_en),
    .poison_set_i (poison_set),
    .wr_ptr_o     (wr_ptr),
    .rd_ptr_o     (rd_ptr),
    .cnt_o        (cnt),
    .full_o       (full),
    .empty_o      (empty),
    .poison_o     (poison)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_en && !flush_i) mem_d[wr_ptr] = in_entry;
  end

  // NOTE: the data array has no reset; out_valid_o already masks stale
  // entries, and leaving it unreset keeps it plain storage without reset fan-out.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign fq.in_ready_o    = in_ready;
  assign fq.out_valid_o   = out_valid;
  assign fq.out_pc_o      = head_entry.pc;
  assign fq.out_inst_o    = head_entry.inst;
  assign fq.out_is_comp_o = head_entry.is_comp;
  assign fq.out_exc_o     = head_entry.exc;
  assign fq.out_spec_o    = head_entry.spec;

  assign count_o    = cnt;
  assign poisoned_o = poison;

`ifndef SYNTHESIS
  a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt <= CNT_W'(DEPTH));
  a_poison_blocks : assert property (@(posedge clk_i) disable iff (!rst_ni)
    poison |-> !in_ready);
`endif

endmodule
